// File: rtl/async_ram.sv
// Simple dual-port RAM: one write port and one read port on a single clock.
// The read data is registered (one cycle of latency). A read and a write to
// the same address in the same cycle return the new data (write-first).
// Asynchronous active-low reset clears the whole array and the read outputs.
module async_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_valid
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Storage array is built from flops so that reset can clear every word.
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  collide;

    // A read hitting the address being written this cycle sees the new data.
    assign collide = we && (wr_addr == rd_addr);

    // Next read-output values: load on re, otherwise hold data and drop valid.
    always_comb begin
        data_out_d = data_out_q;
        rd_valid_d = re;
        if (re) begin
            data_out_d = collide ? data_in : mem_q[rd_addr];
        end
    end

    // Array write port; reset clears every word and blocks any write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    // Registered read data and its one-cycle valid strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            data_out_q <= data_out_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_async_ram.sv
// Self-checking bench for async_ram: directed scenarios plus random traffic,
// a reference memory model, and a scoreboard queue drained by a monitor.
module tb_async_ram;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 1 << AW;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          we = 1'b0;
    logic          re = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          rd_valid;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    async_ram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .re       (re),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .data_in  (data_in),
        .data_out (data_out),
        .rd_valid (rd_valid)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0] mem_m [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            exp_edge_q[$];
    logic [DW-1:0] hold_exp = '0;
    bit            mon_en = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        exp_q.delete();
        exp_edge_q.delete();
        hold_exp = '0;
    endtask

    // ---------------- driver ----------------
    // One cycle of stimulus; inputs change just after the falling edge.
    task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                         input logic r, input logic [AW-1:0] ra);
        @(negedge clk);
        #1;
        we = w; wr_addr = wa; data_in = d; re = r; rd_addr = ra;
        if (rst_n) begin
            if (r) begin
                exp_q.push_back((w && wa == ra) ? d : mem_m[ra]);
                exp_edge_q.push_back(cyc + 1);
            end
            if (w) mem_m[wa] = d;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        drive(1'b1, a, d, 1'b0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        drive(1'b0, '0, '0, 1'b1, a);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_n) begin
                chk("reset_data_out", data_out, 0);
                chk("reset_rd_valid", rd_valid, 0);
            end else if (rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rd_valid", rd_valid, 0);
                end else begin
                    logic [DW-1:0] e;
                    int            en;
                    e  = exp_q.pop_front();
                    en = exp_edge_q.pop_front();
                    chk("read_latency", cyc, en);
                    chk("read_data", data_out, e);
                    hold_exp = e;
                end
            end else begin
                chk("rd_valid_low", rd_valid, 0);
                if (exp_edge_q.size() != 0 && exp_edge_q[0] == cyc) begin
                    chk("missing_rd_valid", rd_valid, 1);
                    void'(exp_q.pop_front());
                    void'(exp_edge_q.pop_front());
                end else begin
                    chk("hold_data_out", data_out, hold_exp);
                end
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: time limit reached, got no end of test, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #1 mon_en = 1'b1;

        // Reset held across several edges with random activity.
        for (int i = 0; i < 4; i++)
            drive(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                  1'($urandom_range(0, 1)), AW'($urandom));
        @(negedge clk);
        #1;
        we = 1'b0; re = 1'b0;
        rst_n = 1'b1;

        // Reads straight after reset return zero.
        rd(8'h00); rd(8'h7F); rd(8'hFF);
        idle(1);

        // Full fill and readback.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(i));
        for (int i = 0; i < DEPTH; i++) rd(AW'(i));
        idle(1);

        // Hold: data_out keeps last value while re is low.
        wr(8'h10, 8'hA5);
        rd(8'h10);
        idle(3);

        // Concurrent ports on different addresses.
        wr(8'h21, 8'h99);
        drive(1'b1, 8'h20, 8'h3C, 1'b1, 8'h21);
        rd(8'h20);
        idle(1);

        // Write-first collision.
        wr(8'h40, 8'h11);
        drive(1'b1, 8'h40, 8'h77, 1'b1, 8'h40);
        idle(1);
        rd(8'h40);
        idle(1);

        // Random traffic; narrow address windows make collisions frequent.
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] wa, ra;
            if (i % 2 == 0) begin
                wa = AW'($urandom_range(0, 3));
                ra = AW'($urandom_range(0, 3));
            end else begin
                wa = AW'($urandom);
                ra = AW'($urandom);
            end
            drive(1'($urandom_range(0, 1)), wa, DW'($urandom), 1'($urandom_range(0, 1)), ra);
        end
        idle(2);

        // Reset pulse between edges after a full fill.
        for (int i = 0; i < DEPTH; i++) wr(AW'(i), DW'(~i));
        drive(1'b1, 8'h05, 8'hEE, 1'b1, 8'hFF);
        @(negedge clk);
        #1;
        we = 1'b1; re = 1'b1; wr_addr = 8'hFF; rd_addr = 8'hFF; data_in = 8'h5A;
        rst_n = 1'b0;
        #1;
        chk("midreset_data_out", data_out, 0);
        chk("midreset_rd_valid", rd_valid, 0);
        model_reset();
        #1;
        rst_n = 1'b1;
        we = 1'b0; re = 1'b0;
        rd(8'hFF);
        rd(8'h05);
        rd(8'h80);
        idle(3);

        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
